// File: rtl/taxi_axil_reg_pkg.sv
// ============================================================================
// taxi_axil_reg_pkg : shared types and constants for the AXI-lite register bridge
// Revision 1.0
// ============================================================================
`default_nettype none

package taxi_axil_reg_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_BUS  = 3'd1,
    WR_RESP = 3'd2,
    RD_BUS  = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Arbitration priority encoding: which side wins when both are eligible
  localparam logic PRIO_WR = 1'b0;
  localparam logic PRIO_RD = 1'b1;

endpackage

`default_nettype wire

// File: rtl/taxi_axil_if.sv
// ============================================================================
// taxi_axil_if : AXI4-lite interface bundle with master/slave modports
// Revision 1.0
// ============================================================================
`default_nettype none

interface taxi_axil_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int STRB_W = DATA_W / 8
) ();

  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport wr_mst (output awaddr, awprot, awvalid, input awready,
                  output wdata, wstrb, wvalid, input wready,
                  input bresp, bvalid, output bready);
  modport wr_slv (input awaddr, awprot, awvalid, output awready,
                  input wdata, wstrb, wvalid, output wready,
                  output bresp, bvalid, input bready);
  modport rd_mst (output araddr, arprot, arvalid, input arready,
                  input rdata, rresp, rvalid, output rready);
  modport rd_slv (input araddr, arprot, arvalid, output arready,
                  output rdata, rresp, rvalid, input rready);

endinterface

`default_nettype wire

// File: rtl/taxi_axil_reg_if_tmo.sv
// ============================================================================
// taxi_axil_reg_if_tmo : ack-wait counter; loads TIMEOUT-1, counts down to 0
// Revision 1.0
// ============================================================================
`default_nettype none

module taxi_axil_reg_if_tmo #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic expired
);

  logic [15:0] r_cnt;

  // Saturates at zero so a held expiry cannot wrap into a long wait
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= 16'(TIMEOUT - 1);
    end else if (dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 16'd1;
    end
  end

  assign expired = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/taxi_axil_reg_if.sv
// ============================================================================
// taxi_axil_reg_if : AXI4-lite slave to single-outstanding enable/ack register bus
// Optional ack timeout (SLVERR on expiry) enabled by TAXI_AXIL_REG_IF_TIMEOUT_EN
// Revision 1.0
// ============================================================================
`default_nettype none

module taxi_axil_reg_if
  import taxi_axil_reg_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  taxi_axil_if.wr_slv              s_axil_wr,
  taxi_axil_if.rd_slv              s_axil_rd,
  output logic [ADDR_W-1:0]        reg_addr,
  output logic                     reg_wr_en,
  output logic [DATA_W-1:0]        reg_wr_data,
  output logic [DATA_W/8-1:0]      reg_wr_strb,
  input  logic                     reg_wr_ack,
  output logic                     reg_rd_en,
  input  logic [DATA_W-1:0]        reg_rd_data,
  input  logic                     reg_rd_ack
);

  localparam int STRB_W    = DATA_W / 8;
  localparam int IF_DATA_W = s_axil_wr.DATA_W;
  localparam int IF_ADDR_W = s_axil_wr.ADDR_W;
  localparam int RD_DATA_W = s_axil_rd.DATA_W;
  localparam int RD_ADDR_W = s_axil_rd.ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(STRB_W - 1);

  if ((DATA_W % 8 != 0) || (DATA_W != IF_DATA_W) || (DATA_W != RD_DATA_W)) begin : g_chk_data_w
    $error("taxi_axil_reg_if: DATA_W must be a multiple of 8 and match the interface");
  end
  if ((ADDR_W < 1) || (ADDR_W > IF_ADDR_W) || (ADDR_W > RD_ADDR_W)) begin : g_chk_addr_w
    $error("taxi_axil_reg_if: ADDR_W must not exceed the interface address width");
  end
  if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_chk_timeout
    $error("taxi_axil_reg_if: TIMEOUT must be in 1..65535");
  end

  state_t              r_state;
  logic                r_prio;
  logic                r_bvalid;
  logic [1:0]          r_bresp;
  logic                r_rvalid;
  logic [1:0]          r_rresp;
  logic [DATA_W-1:0]   r_rdata;
  logic                w_wr_elig;
  logic                w_rd_elig;
  logic                w_wr_sel;
  logic                w_rd_sel;
  logic                w_tmo_expired;
  logic                w_unused;

  assign w_wr_elig = s_axil_wr.awvalid && s_axil_wr.wvalid;
  assign w_rd_elig = s_axil_rd.arvalid;
  assign w_wr_sel  = (r_state == IDLE) && w_wr_elig && (!w_rd_elig || (r_prio == PRIO_WR));
  assign w_rd_sel  = (r_state == IDLE) && w_rd_elig && (!w_wr_elig || (r_prio == PRIO_RD));

  assign s_axil_wr.awready = w_wr_sel;
  assign s_axil_wr.wready  = w_wr_sel;
  assign s_axil_wr.bvalid  = r_bvalid;
  assign s_axil_wr.bresp   = r_bresp;
  assign s_axil_rd.arready = w_rd_sel;
  assign s_axil_rd.rvalid  = r_rvalid;
  assign s_axil_rd.rresp   = r_rresp;
  assign s_axil_rd.rdata   = r_rdata;

  // Protection bits and upper address bits have no meaning on the register bus
  assign w_unused = ^{s_axil_wr.awprot, s_axil_rd.arprot, s_axil_wr.awaddr, s_axil_rd.araddr};

`ifdef TAXI_AXIL_REG_IF_TIMEOUT_EN
  logic w_tmo_dec;
  assign w_tmo_dec = ((r_state == WR_BUS) && !reg_wr_ack) ||
                     ((r_state == RD_BUS) && !reg_rd_ack);

  taxi_axil_reg_if_tmo #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_wr_sel || w_rd_sel),
    .dec     (w_tmo_dec),
    .expired (w_tmo_expired)
  );
`else
  assign w_tmo_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_prio      <= PRIO_WR;
      reg_addr    <= '0;
      reg_wr_data <= '0;
      reg_wr_strb <= '0;
      reg_wr_en   <= 1'b0;
      reg_rd_en   <= 1'b0;
      r_bvalid    <= 1'b0;
      r_bresp     <= RESP_OKAY;
      r_rvalid    <= 1'b0;
      r_rresp     <= RESP_OKAY;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_wr_sel) begin
            reg_addr    <= s_axil_wr.awaddr[ADDR_W-1:0] & ADDR_MASK;
            reg_wr_data <= s_axil_wr.wdata;
            reg_wr_strb <= s_axil_wr.wstrb;
            reg_wr_en   <= 1'b1;
            r_prio      <= PRIO_RD;
            r_state     <= WR_BUS;
          end else if (w_rd_sel) begin
            reg_addr    <= s_axil_rd.araddr[ADDR_W-1:0] & ADDR_MASK;
            reg_rd_en   <= 1'b1;
            r_prio      <= PRIO_WR;
            r_state     <= RD_BUS;
          end
        end
        // An ack arriving in the expiry cycle takes precedence over the timeout
        WR_BUS: begin
          if (reg_wr_ack || w_tmo_expired) begin
            reg_wr_en <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= reg_wr_ack ? RESP_OKAY : RESP_SLVERR;
            r_state   <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (s_axil_wr.bready) begin
            r_bvalid <= 1'b0;
            r_state  <= IDLE;
          end
        end
        RD_BUS: begin
          if (reg_rd_ack || w_tmo_expired) begin
            reg_rd_en <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rresp   <= reg_rd_ack ? RESP_OKAY : RESP_SLVERR;
            r_rdata   <= reg_rd_ack ? reg_rd_data : '0;
            r_state   <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (s_axil_rd.rready) begin
            r_rvalid <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
